// File: rtl/imul53_arbiter.sv
// imul53_arbiter: round-robin arbiter sharing one non-pipelined 53x53 multiplier between two requesters,
// with a minimum-latency rdy window and a timeout abort.
module imul53_arbiter #(
  parameter int min_latency = 16,
  parameter int timeout     = 32
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [52:0]  i_a0,
  input  logic [52:0]  i_b0,
  input  logic [52:0]  i_a1,
  input  logic [52:0]  i_b1,
  output logic         o_ack0,
  output logic         o_ack1,
  output logic         o_valid0,
  output logic         o_valid1,
  output logic [105:0] o_result,
  output logic [6:0]   o_shift,
  output logic         o_overflow,
  output logic         o_err,
  output logic         o_mul_ena,
  output logic [52:0]  o_mul_a,
  output logic [52:0]  o_mul_b,
  input  logic [105:0] i_mul_result,
  input  logic [6:0]   i_mul_shift,
  input  logic         i_mul_overflow,
  input  logic         i_mul_rdy
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  localparam logic [5:0] rdy_min = 6'(min_latency - 1);
  localparam logic [5:0] to_max  = 6'(timeout - 1);
  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic         ack0_q, ack0_d, ack1_q, ack1_d;
  logic         valid0_q, valid0_d, valid1_q, valid1_d;
  logic         mul_ena_q, mul_ena_d;
  logic [52:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [105:0] result_q, result_d;
  logic [6:0]   shift_q, shift_d;
  logic         overflow_q, overflow_d, err_q, err_d;
  logic         pick1, rdy_ok, to_hit;
  // last_q doubles as the granted requester while an operation is in flight
  assign pick1  = i_req1 & (~i_req0 | ~last_q);
  assign rdy_ok = i_mul_rdy & (cnt_q >= rdy_min);
  assign to_hit = cnt_q >= to_max;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    mul_ena_d  = 1'b0;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    result_d   = result_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (i_req0 | i_req1) begin
        state_d   = BUSY;
        cnt_d     = 6'd0;
        last_d    = pick1;
        ack0_d    = ~pick1;
        ack1_d    = pick1;
        mul_ena_d = 1'b1;
        mul_a_d   = pick1 ? i_a1 : i_a0;
        mul_b_d   = pick1 ? i_b1 : i_b0;
      end
      BUSY: begin
        cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
        if (rdy_ok | to_hit) begin
          state_d    = RESP;
          valid0_d   = ~last_q;
          valid1_d   = last_q;
          result_d   = rdy_ok ? i_mul_result : '0;
          shift_d    = rdy_ok ? i_mul_shift : '0;
          overflow_d = rdy_ok & i_mul_overflow;
          err_d      = ~rdy_ok;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      mul_ena_q  <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      result_q   <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      mul_ena_q  <= mul_ena_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      result_q   <= result_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end
  assign o_ack0     = ack0_q;
  assign o_ack1     = ack1_q;
  assign o_valid0   = valid0_q;
  assign o_valid1   = valid1_q;
  assign o_mul_ena  = mul_ena_q;
  assign o_mul_a    = mul_a_q;
  assign o_mul_b    = mul_b_q;
  assign o_result   = result_q;
  assign o_shift    = shift_q;
  assign o_overflow = overflow_q;
  assign o_err      = err_q;
endmodule

// File: tb/tb_imul53_arbiter.sv
// tb_imul53_arbiter: directed checks of grant, latency window, timeout, stale rdy and reset behaviour.
module tb_imul53_arbiter;
  logic         clk = 1'b0, nrst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [52:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, valid0, valid1, ovf, err, ena;
  logic [105:0] result;
  logic [6:0]   shift;
  logic [52:0]  mul_a, mul_b;
  logic [105:0] m_result = '0;
  logic [6:0]   m_shift = '0;
  logic         m_ovf = 1'b0, m_rdy = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, t_prev = 0;
  imul53_arbiter dut (
    .i_clk(clk), .i_nrst(nrst), .i_req0(req0), .i_req1(req1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
    .o_ack0(ack0), .o_ack1(ack1), .o_valid0(valid0), .o_valid1(valid1),
    .o_result(result), .o_shift(shift), .o_overflow(ovf), .o_err(err),
    .o_mul_ena(ena), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_result(m_result), .i_mul_shift(m_shift), .i_mul_overflow(m_ovf), .i_mul_rdy(m_rdy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [105:0] obs, input logic [105:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ena(input string tag);
    int k = 0;
    while (ena !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 106'(ena), 106'd1);
  endtask
  task automatic rdy_pulse(input logic [105:0] r, input logic [6:0] s, input logic o);
    m_result = r; m_shift = s; m_ovf = o; m_rdy = 1'b1;
    step(1);
    m_rdy = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_ctl", 106'({ack0, ack1, valid0, valid1, ovf, err, ena, shift}), 106'd0);
    chk("rst_res", result, 106'd0);
    chk("rst_ops", {mul_a, mul_b}, 106'd0);
    nrst = 1'b1;
    step(1);
    // single request: ack0 + mul_ena in the cycle after the request is seen
    req0 = 1'b1; a0 = 53'd3; b0 = 53'd5;
    wait_ena("single_ena");
    chk("single_ack", 106'({ack0, ack1}), 106'b10);
    chk("single_ops", {mul_a, mul_b}, {53'd3, 53'd5});
    req0 = 1'b0;
    step(15);
    chk("single_noearly", 106'(valid0), 106'd0);
    rdy_pulse(106'd15, 7'd3, 1'b0);
    chk("single_valid", 106'({valid0, valid1, err}), 106'b100);
    chk("single_result", result, 106'd15);
    chk("single_shift", 106'(shift), 106'd3);
    step(1);
    chk("single_hold", 106'({valid0, result}), 106'd15);
    // timeout: no rdy ever
    req1 = 1'b1; a1 = 53'd7; b1 = 53'd9;
    wait_ena("to_ena");
    chk("to_ack", 106'({ack0, ack1}), 106'b01);
    req1 = 1'b0;
    step(31);
    chk("to_noearly", 106'(valid1), 106'd0);
    step(1);
    chk("to_valid", 106'({valid0, valid1, err}), 106'b011);
    chk("to_result", result, 106'd0);
    chk("to_shift", 106'({shift, ovf}), 106'd0);
    // stale rdy 5 cycles into the next operation is discarded
    req0 = 1'b1; a0 = 53'd2; b0 = 53'd11;
    wait_ena("stale_ena");
    req0 = 1'b0;
    step(5);
    rdy_pulse(106'd999, 7'd1, 1'b1);
    chk("stale_ignored", 106'({valid0, valid1}), 106'd0);
    step(9);
    rdy_pulse(106'd22, 7'd2, 1'b0);
    chk("stale_valid", 106'({valid0, valid1, err}), 106'b100);
    chk("stale_result", result, 106'd22);
    // rdy coinciding with timeout wins
    req1 = 1'b1; a1 = 53'd4; b1 = 53'd6;
    wait_ena("coin_ena");
    req1 = 1'b0;
    step(31);
    rdy_pulse(106'd24, 7'd5, 1'b1);
    chk("coin_valid", 106'({valid0, valid1, err}), 106'b010);
    chk("coin_result", result, 106'd24);
    chk("coin_flags", 106'({shift, ovf}), 106'({7'd5, 1'b1}));
    // rdy pulsed in IDLE is ignored
    step(1);
    rdy_pulse(106'd77, 7'd0, 1'b0);
    chk("idle_rdy_nv", 106'({valid0, valid1, ena}), 106'd0);
    step(1);
    chk("idle_rdy_hold", result, 106'd24);
    // reset in mid-BUSY at counter 7
    req0 = 1'b1; a0 = 53'd1; b0 = 53'd1;
    wait_ena("rst_busy_ena");
    req0 = 1'b0;
    step(7);
    nrst = 1'b0;
    #1;
    chk("arst_ctl", 106'({ack0, ack1, valid0, valid1, ovf, err, ena, shift}), 106'd0);
    chk("arst_res", result, 106'd0);
    chk("arst_ops", {mul_a, mul_b}, 106'd0);
    step(1);
    nrst = 1'b1;
    rdy_pulse(106'd5, 7'd0, 1'b0);
    chk("arst_stale_nv", 106'({valid0, valid1}), 106'd0);
    // contention from reset: 0,1,0,1 with gaps of at least min_latency+2
    a0 = 53'd10; b0 = 53'd11; a1 = 53'd20; b1 = 53'd21;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ena("rr_ena");
      if (i > 0) chk("rr_gap", 106'(cyc - t_prev >= 18), 106'd1);
      t_prev = cyc;
      chk("rr_ack", 106'({ack0, ack1}), (i % 2 == 0) ? 106'b10 : 106'b01);
      chk("rr_ops", {mul_a, mul_b}, (i % 2 == 0) ? {53'd10, 53'd11} : {53'd20, 53'd21});
      step(15);
      rdy_pulse(106'(100 + i), 7'd0, 1'b0);
      chk("rr_valid", 106'({valid0, valid1}), (i % 2 == 0) ? 106'b10 : 106'b01);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
